// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  // Access width encoding; 2'd3 is reserved and rejected as an error.
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Request payload as selected from the winning requester.
  typedef struct packed {
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    mem_op_sz_e       size;
  } mem_req_t;

  // Number of bytes touched by an access; 0 marks an invalid encoding.
  function automatic logic [2:0] mem_op_bytes(input mem_op_sz_e sz);
    case (sz)
      BYTE:    return 3'd1;
      HWORD:   return 3'd2;
      WORD:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Zero-extend the low bytes of a little-endian read according to access size.
  function automatic logic [XLEN-1:0] mem_zext(input logic [XLEN-1:0] d, input mem_op_sz_e sz);
    case (sz)
      BYTE:    return {24'd0, d[7:0]};
      HWORD:   return {16'd0, d[15:0]};
      WORD:    return d;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic        found;
  logic [31:0] k;

  // Scan requesters starting at the pointer and take the first one found.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      k = (32'(ptr_i) + off) % NumReq;
      if (en_i && !found && req_i[k[IdxW-1:0]]) begin
        found               = 1'b1;
        gnt_o[k[IdxW-1:0]]  = 1'b1;
        idx_o               = k[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between requesters.
// One access in flight; alignment and bounds are checked before the memory is driven.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NumReq          = 2,
  parameter int unsigned MemoryBytesSize = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NumReq-1:0]            i_req_valid,
  output logic [NumReq-1:0]            o_req_ready,
  input  logic [NumReq-1:0]            i_req_we,
  input  logic [NumReq-1:0][XLEN-1:0]  i_req_addr,
  input  logic [NumReq-1:0][XLEN-1:0]  i_req_wdata,
  input  mem_op_sz_e                   i_req_size [NumReq],
  output logic [NumReq-1:0]            o_rsp_valid,
  input  logic [NumReq-1:0]            i_rsp_ready,
  output logic [XLEN-1:0]              o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic                         o_mem_we,
  output logic                         o_mem_re,
  output logic [XLEN-1:0]              o_mem_addr,
  output logic [XLEN-1:0]              o_mem_data,
  output mem_op_sz_e                   o_mem_size,
  input  logic [XLEN-1:0]              i_mem_rdata
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  arb_state_e          state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic                err_q;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [XLEN-1:0]     rsp_rdata_q;
  logic                rsp_err_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic [XLEN-1:0]     mem_addr_q;
  logic [XLEN-1:0]     mem_data_q;
  mem_op_sz_e          mem_size_q;

  logic [NumReq-1:0]   gnt;
  logic [IdxW-1:0]     win_idx;
  mem_req_t            req_d;
  logic                err_d;
  logic [IdxW-1:0]     ptr_d;
  logic [XLEN:0]       end_addr;
  logic                misaligned;
  logic [2:0]          nbytes;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == ARB_IDLE),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  // Accept is combinational so the request is taken in the cycle it is granted.
  assign o_req_ready = gnt;

  // Select the winning request, classify it and compute the advanced pointer.
  always_comb begin
    req_d.we    = i_req_we[win_idx];
    req_d.addr  = i_req_addr[win_idx];
    req_d.wdata = i_req_wdata[win_idx];
    req_d.size  = i_req_size[win_idx];
    nbytes      = mem_op_bytes(req_d.size);
    end_addr    = {1'b0, req_d.addr} + (XLEN+1)'(nbytes);
    misaligned  = ((req_d.size == HWORD) && req_d.addr[0]) ||
                  ((req_d.size == WORD)  && (req_d.addr[1:0] != 2'b00));
    err_d       = misaligned || (nbytes == 3'd0) ||
                  (end_addr > (XLEN+1)'(MemoryBytesSize));
    ptr_d       = (win_idx == IdxW'(NumReq-1)) ? '0 : win_idx + IdxW'(1);
  end

  // Arbitration FSM; memory controls are loaded on grant so they are live only in ARB_ACCESS.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_size_q  <= BYTE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|gnt) begin
            state_q    <= ARB_ACCESS;
            ptr_q      <= ptr_d;
            owner_q    <= win_idx;
            err_q      <= err_d;
            mem_we_q   <= !err_d && req_d.we;
            mem_re_q   <= !err_d && !req_d.we;
            mem_addr_q <= err_d ? '0 : req_d.addr;
            mem_data_q <= err_d ? '0 : req_d.wdata;
            mem_size_q <= err_d ? BYTE : req_d.size;
          end
        end
        ARB_ACCESS: begin
          state_q     <= ARB_RESP;
          rsp_valid_q <= NumReq'(1) << owner_q;
          rsp_rdata_q <= mem_re_q ? mem_zext(i_mem_rdata, mem_size_q) : '0;
          rsp_err_q   <= err_q;
          mem_we_q    <= 1'b0;
          mem_re_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_data_q  <= '0;
          mem_size_q  <= BYTE;
        end
        ARB_RESP: begin
          if (i_rsp_ready[owner_q]) begin
            state_q     <= ARB_IDLE;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_re    = mem_re_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_mem_size  = mem_size_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 16-byte behavioural data memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  mem_op_sz_e        req_size [2];
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_data;
  mem_op_sz_e        mem_size;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  logic [7:0] mem [16];

  dmem_arbiter #(.NumReq(2), .MemoryBytesSize(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_size  (req_size),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_data),
    .o_mem_size  (mem_size),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: cleared by reset, byte-granular little-endian writes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_op_bytes(mem_size)) && (mem_addr + 32'(i)) < 32'd16)
          mem[4'(mem_addr + 32'(i))] <= mem_data[8*i +: 8];
    end
  end

  // Combinational read returns the full word at the address; the arbiter trims it.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if ((mem_addr + 32'(i)) < 32'd16)
        mem_rdata[8*i +: 8] = mem[4'(mem_addr + 32'(i))];
  end

  // Count cycles with memory strobes active.
  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
  end

  task automatic clear_inputs();
    req_valid = '0;
    rsp_ready = 2'b11;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_size[0] = BYTE;
    req_size[1] = BYTE;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive one request, wait for accept and response, hand back response and latency.
  task automatic do_req(input int r, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input mem_op_sz_e sz,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r]  = addr;
    req_wdata[r] = wd;
    req_size[r]  = sz;
    rsp_ready[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready[r]) begin
      errors++;
      $display("FAIL grant_timeout r=%0d addr=%h: no ready within 20 cycles", r, addr);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat   = n;
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_handshake rsp_valid=%b req_ready=%b required 00/00", rsp_valid, req_ready);
    end
    checks++;
    if ({mem_we, mem_re} !== 2'b00 || mem_addr !== 32'd0 || mem_data !== 32'd0 || mem_size !== BYTE) begin
      errors++;
      $display("FAIL reset_mem we=%b re=%b addr=%h data=%h size=%0d required all 0",
               mem_we, mem_re, mem_addr, mem_data, mem_size);
    end
    checks++;
    if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp rdata=%h err=%b required 0/0", rsp_rdata, rsp_err);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          w0;
    int          r0;
    w0 = we_cnt; r0 = re_cnt;
    do_req(0, 1'b1, 32'd4, 32'hDEADBEEF, WORD, rd, e, lat);
    checks++;
    if (we_cnt - w0 !== 1 || re_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL store_strobes we_cycles=%0d re_cycles=%0d required 1/0", we_cnt - w0, re_cnt - r0);
    end
    checks++;
    if (rd !== 32'd0 || e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL store_rsp rdata=%h err=%b lat=%0d required 0/0/2", rd, e, lat);
    end
    w0 = we_cnt; r0 = re_cnt;
    do_req(0, 1'b0, 32'd4, 32'd0, WORD, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL load_word rdata=%h err=%b required deadbeef/0", rd, e);
    end
    checks++;
    if (lat !== 2 || we_cnt - w0 !== 0 || re_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL load_timing lat=%0d we=%0d re=%0d required 2/0/1", lat, we_cnt - w0, re_cnt - r0);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd;
    logic        e;
    int          lat;
    do_req(1, 1'b1, 32'd2, 32'h0000A5A5, HWORD, rd, e, lat);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL hword_store err=%b required 0", e);
    end
    do_req(1, 1'b0, 32'd3, 32'd0, BYTE, rd, e, lat);
    checks++;
    if (rd !== 32'h000000A5 || e !== 1'b0) begin
      errors++;
      $display("FAIL byte_load rdata=%h err=%b required 000000a5/0", rd, e);
    end
    do_req(0, 1'b0, 32'd0, 32'd0, WORD, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A50000 || e !== 1'b0) begin
      errors++;
      $display("FAIL word_after_hword rdata=%h err=%b required a5a50000/0", rd, e);
    end
  endtask

  task automatic test_errors();
    mem_op_sz_e  sz_t [7];
    logic [31:0] ad_t [7];
    logic        ee_t [7];
    logic [31:0] rd_t [7];
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          w0;
    int          r0;
    do_req(0, 1'b1, 32'd12, 32'h11223344, WORD, rd, e, lat);
    w0 = we_cnt;
    do_req(1, 1'b1, 32'd14, 32'hFFFFFFFF, WORD, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'd0 || we_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL oob_store err=%b rdata=%h we_cycles=%0d required 1/0/0", e, rd, we_cnt - w0);
    end
    sz_t[0] = HWORD; ad_t[0] = 32'd1;  ee_t[0] = 1'b1; rd_t[0] = 32'd0;
    sz_t[1] = WORD;  ad_t[1] = 32'd2;  ee_t[1] = 1'b1; rd_t[1] = 32'd0;
    sz_t[2] = WORD;  ad_t[2] = 32'd14; ee_t[2] = 1'b1; rd_t[2] = 32'd0;
    sz_t[3] = BYTE;  ad_t[3] = 32'd16; ee_t[3] = 1'b1; rd_t[3] = 32'd0;
    sz_t[4] = mem_op_sz_e'(2'd3); ad_t[4] = 32'd0; ee_t[4] = 1'b1; rd_t[4] = 32'd0;
    sz_t[5] = BYTE;  ad_t[5] = 32'd15; ee_t[5] = 1'b0; rd_t[5] = 32'h00000011;
    sz_t[6] = WORD;  ad_t[6] = 32'd12; ee_t[6] = 1'b0; rd_t[6] = 32'h11223344;
    for (int i = 0; i < 7; i++) begin
      w0 = we_cnt; r0 = re_cnt;
      do_req(i % 2, 1'b0, ad_t[i], 32'd0, sz_t[i], rd, e, lat);
      checks++;
      if (e !== ee_t[i] || rd !== rd_t[i]) begin
        errors++;
        $display("FAIL chk_vec%0d addr=%0d err=%b rdata=%h required %b/%h", i, ad_t[i], e, rd, ee_t[i], rd_t[i]);
      end
      checks++;
      if (we_cnt - w0 !== 0 || re_cnt - r0 !== (ee_t[i] ? 0 : 1)) begin
        errors++;
        $display("FAIL chk_strobe%0d we=%0d re=%0d required 0/%0d", i, we_cnt - w0, re_cnt - r0, ee_t[i] ? 0 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk); #1;
    rsp_ready    = 2'b10;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd4; req_size[0] = WORD;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd4; req_size[1] = BYTE;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d rsp_valid=%b rdata=%h err=%b req_ready=%b required 01/deadbeef/0/00",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    @(posedge clk); #1 rsp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_handshake rsp_valid=%b req_ready=%b required 01/00", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_regrant rsp_valid=%b req_ready=%b required 00/10", rsp_valid, req_ready);
    end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsp_rdata !== 32'h000000EF || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_second rdata=%h err=%b required 000000ef/0", rsp_rdata, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_req();
    int g;
    int cyc;
    int last;
    do_reset();
    req_we    = 2'b00;
    req_addr[0] = 32'd4; req_size[0] = WORD;
    req_addr[1] = 32'd8; req_size[1] = HWORD;
    req_valid = 2'b11;
    g = 0; cyc = 0; last = -1;
    while (g < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== 2'b00) begin
        checks++;
        if (last < 0 || rsp_valid !== (2'b01 << last)) begin
          errors++;
          $display("FAIL rsp_onehot rsp_valid=%b owner=%0d", rsp_valid, last);
        end
      end
      if (req_ready !== 2'b00) begin
        checks++;
        if (req_ready !== (2'b01 << (g % 2))) begin
          errors++;
          $display("FAIL grant_order grant#%0d req_ready=%b required %b", g, req_ready, 2'b01 << (g % 2));
        end
        last = req_ready[1] ? 1 : 0;
        g++;
      end
    end
    checks++;
    if (g !== 6) begin
      errors++;
      $display("FAIL two_req_count grants=%0d required 6", g);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd8;
    req_wdata[0] = 32'hCAFEF00D; req_size[0] = WORD;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL access_we mem_we=%b required 1", mem_we);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_re} !== 2'b00 || rsp_valid !== 2'b00 || mem_addr !== 32'd0 || mem_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset we=%b re=%b rsp_valid=%b addr=%h data=%h required all 0",
               mem_we, mem_re, rsp_valid, mem_addr, mem_data);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    req_we = 2'b00;
    req_addr[0] = 32'd8; req_size[0] = WORD;
    req_addr[1] = 32'd8; req_size[1] = WORD;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant req_ready=%b required 01", req_ready);
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 2'b10 || n !== 2) begin
      errors++;
      $display("FAIL post_reset_next req_ready=%b wait=%0d required 10/2", req_ready, n);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_two_req();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
